// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response channel, execute redirect and
// the decode slot. The master side is the fetch unit.
interface instr_fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [31:0] dec_pc_plus4;

   modport master (
      output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, dec_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, dec_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited word reads to instruction memory, in-order response FIFO feeding
// decode, and redirect handling that flushes the buffer and drops stale in-flight responses.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetchEntry_t;

   fetchEntry_t   fifoMem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [CW-1:0] count, outstanding, drop;
   logic [31:0]   fpc, rspPc, redirTarget;
   logic [CW:0]   creditUse;
   logic          pop, reqFire, rspKeep;
   logic          unusedPcBits;

   assign redirTarget  = {bus.redirect_pc[31:2], 2'b00};
   assign unusedPcBits = ^bus.redirect_pc[1:0];

   assign bus.dec_valid    = (count != '0);
   assign pop              = bus.dec_valid & bus.dec_ready;
   assign bus.dec_instr    = bus.dec_valid ? fifoMem[rdPtr].instr : 32'h0;
   assign bus.dec_pc       = bus.dec_valid ? fifoMem[rdPtr].pc : 32'h0;
   assign bus.dec_pc_plus4 = bus.dec_valid ? fifoMem[rdPtr].pc + 32'd4 : 32'h0;

   // A slot is reserved for every in-flight request, so a response can never find the FIFO full.
   assign creditUse          = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
   assign bus.imem_req_valid = reset && !bus.redirect && (creditUse < DEPTH_EXT);
   assign bus.imem_req_addr  = fpc;
   assign reqFire            = bus.imem_req_valid & bus.imem_req_ready;
   assign rspKeep            = bus.imem_rsp_valid && (drop == '0) && !bus.redirect;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpc         <= RESET_PC;
         rspPc       <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
         count       <= '0;
         wrPtr       <= '0;
         rdPtr       <= '0;
      end else begin
         outstanding <= outstanding + CW'(reqFire) - CW'(bus.imem_rsp_valid);
         if (bus.redirect) begin
            fpc   <= redirTarget;
            rspPc <= redirTarget;
            // outstanding already includes responses marked for dropping by earlier redirects,
            // so every response still in flight after this cycle becomes stale.
            drop  <= outstanding - CW'(bus.imem_rsp_valid);
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
         end else begin
            if (reqFire) fpc <= fpc + 32'd4;
            if (bus.imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
            if (rspKeep) begin
               rspPc <= rspPc + 32'd4;
               wrPtr <= wrPtr + AW'(1);
            end
            if (pop) rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(rspKeep) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rspKeep) fifoMem[wrPtr] <= '{instr: bus.imem_rsp_data, pc: rspPc};
   end

   assert property (@(posedge clk) disable iff (!reset) !(rspKeep && !pop && count == FULL));
   assert property (@(posedge clk) disable iff (!reset) outstanding <= FULL);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-configurable in-order memory model, a stream-level
// reference (consecutive PCs from the last redirect target), directed tables and random traffic.
module tb_instr_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus();
   instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct { int unsigned due; logic [31:0] data; } rsp_t;
   typedef struct {
      logic        decRdy;
      logic        expReqValid;
      logic [31:0] expReqAddr;
      logic        expDecValid;
      logic [31:0] expDecPc;
      logic [31:0] expInstr;
   } vec_t;

   rsp_t        rspQ[$];
   vec_t        tbl[13];
   int unsigned cyc, lat, lastDue;
   int          nChecks, nErrors, reqCount, popCount;
   logic        nRst, rdy, dRdy, redir;
   logic [31:0] redirPc, expPc, expReqPc, prevAddr;
   logic        prevRedir, prevStall;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return {2'b00, a[31:2]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: decode must see memory words at consecutive PCs from the last target, each once.
   task automatic observe();
      int unsigned d;
      if (!reset) begin
         chk("rst_req_valid", bus.imem_req_valid, 0);
         chk("rst_dec_valid", bus.dec_valid, 0);
         chk("rst_dec_bus", bus.dec_instr | bus.dec_pc | bus.dec_pc_plus4, 0);
         rspQ.delete();
         lastDue   = 0;
         expPc     = RESET_PC;
         expReqPc  = RESET_PC;
         prevRedir = 1'b0;
         prevStall = 1'b0;
         return;
      end
      if (!bus.dec_valid) chk("bubble_zero", bus.dec_instr | bus.dec_pc | bus.dec_pc_plus4, 0);
      if (prevRedir) chk("dec_valid_after_redirect", bus.dec_valid, 0);
      if (bus.redirect) chk("no_req_in_redirect", bus.imem_req_valid, 0);
      if (prevStall && !bus.redirect) begin
         chk("stall_req_valid", bus.imem_req_valid, 1);
         chk("stall_req_addr", bus.imem_req_addr, prevAddr);
      end
      if (bus.dec_valid && bus.dec_ready) begin
         chk("dec_pc", bus.dec_pc, expPc);
         chk("dec_instr", bus.dec_instr, memData(expPc));
         chk("dec_pc_plus4", bus.dec_pc_plus4, expPc + 32'd4);
         expPc += 32'd4;
         popCount++;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         chk("req_addr", bus.imem_req_addr, expReqPc);
         d = cyc + lat;
         if (d <= lastDue) d = lastDue + 1;
         rspQ.push_back('{d, memData(bus.imem_req_addr)});
         lastDue = d;
         expReqPc += 32'd4;
         reqCount++;
      end
      chk("in_flight_le_depth", rspQ.size() <= DEPTH, 1);
      prevStall = bus.imem_req_valid && !bus.imem_req_ready;
      prevAddr  = bus.imem_req_addr;
      prevRedir = bus.redirect;
      if (bus.redirect) begin
         expPc    = {bus.redirect_pc[31:2], 2'b00};
         expReqPc = expPc;
      end
   endtask

   task automatic cycle();
      rsp_t r;
      @(posedge clk);
      cyc++;
      #1;
      reset              = nRst;
      bus.imem_req_ready = rdy;
      bus.dec_ready      = dRdy;
      bus.redirect       = redir;
      bus.redirect_pc    = redirPc;
      if (rspQ.size() > 0 && rspQ[0].due == cyc) begin
         r = rspQ.pop_front();
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = r.data;
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'h0;
      end
      @(negedge clk);
      observe();
   endtask

   task automatic doReset();
      nRst = 1'b0;
      cycle();
      cycle();
      nRst = 1'b1;
   endtask

   task automatic waitDecValid(input string name, output int waited);
      waited = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         waited++;
         if (bus.dec_valid) return;
      end
      chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      int w;
      nChecks = 0; nErrors = 0; cyc = 0; lat = 1; lastDue = 0;
      reqCount = 0; popCount = 0;
      nRst = 1'b0; rdy = 1'b1; dRdy = 1'b1; redir = 1'b0; redirPc = 32'h0;
      prevRedir = 1'b0; prevStall = 1'b0; prevAddr = 32'h0;
      expPc = RESET_PC; expReqPc = RESET_PC;
      bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
      bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.dec_ready = 1'b1;

      // Row k = k-th cycle after reset release, L=1; rows 8-10 stall decode to hit the credit limit.
      tbl[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0};
      tbl[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  32'd0};
      tbl[2]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  32'd0};
      tbl[3]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  32'd1};
      tbl[4]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  32'd2};
      tbl[5]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 32'd3};
      tbl[6]  = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd16, 32'd4};
      tbl[7]  = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd20, 32'd5};
      tbl[8]  = '{1'b0, 1'b1, 32'd32, 1'b1, 32'd24, 32'd6};
      tbl[9]  = '{1'b0, 1'b1, 32'd36, 1'b1, 32'd24, 32'd6};
      tbl[10] = '{1'b0, 1'b0, 32'd40, 1'b1, 32'd24, 32'd6};
      tbl[11] = '{1'b1, 1'b1, 32'd40, 1'b1, 32'd24, 32'd6};
      tbl[12] = '{1'b1, 1'b1, 32'd44, 1'b1, 32'd28, 32'd7};

      doReset();
      for (int i = 0; i < 13; i++) begin
         dRdy = tbl[i].decRdy;
         cycle();
         chk($sformatf("t1_req_valid[%0d]", i), bus.imem_req_valid, tbl[i].expReqValid);
         chk($sformatf("t1_req_addr[%0d]", i), bus.imem_req_addr, tbl[i].expReqAddr);
         chk($sformatf("t1_dec_valid[%0d]", i), bus.dec_valid, tbl[i].expDecValid);
         chk($sformatf("t1_dec_pc[%0d]", i), bus.dec_pc, tbl[i].expDecPc);
         chk($sformatf("t1_dec_instr[%0d]", i), bus.dec_instr, tbl[i].expInstr);
      end

      // Decode stalled from release: credits cap requests, then an ordered drain.
      lat = 1; dRdy = 1'b0; reqCount = 0;
      doReset();
      repeat (10) cycle();
      chk("t2_req_count_le_depth", reqCount <= DEPTH && reqCount > 0, 1);
      chk("t2_req_valid_low", bus.imem_req_valid, 0);
      chk("t2_dec_valid", bus.dec_valid, 1);
      popCount = 0; dRdy = 1'b1;
      repeat (20) cycle();
      chk("t2_drain_rate", popCount >= 18, 1);

      // L=3, redirect with two requests in flight to an unaligned target.
      lat = 3; dRdy = 1'b1;
      doReset();
      cycle();
      cycle();
      redir = 1'b1; redirPc = 32'h103;
      cycle();
      redir = 1'b0;
      waitDecValid("t3", w);
      chk("t3_latency", w, 5);
      chk("t3_dec_pc", bus.dec_pc, 32'h100);
      chk("t3_dec_instr", bus.dec_instr, memData(32'h100));
      chk("t3_dec_pc_plus4", bus.dec_pc_plus4, 32'h104);

      // Redirect coinciding with a response and a decode pop.
      lat = 1;
      doReset();
      repeat (6) cycle();
      redir = 1'b1; redirPc = 32'h200;
      cycle();
      chk("t4_setup_rsp_pop", {bus.imem_rsp_valid, bus.dec_valid, bus.dec_ready}, 3'b111);
      redir = 1'b0;
      waitDecValid("t4", w);
      chk("t4_dec_pc", bus.dec_pc, 32'h200);
      chk("t4_dec_instr", bus.dec_instr, memData(32'h200));

      // Memory not ready at fpc=0x20.
      redir = 1'b1; redirPc = 32'h20;
      cycle();
      redir = 1'b0; rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk($sformatf("t5_hold_valid[%0d]", i), bus.imem_req_valid, 1);
         chk($sformatf("t5_hold_addr[%0d]", i), bus.imem_req_addr, 32'h20);
      end
      rdy = 1'b1;
      cycle();
      chk("t5_resume_addr0", bus.imem_req_addr, 32'h20);
      cycle();
      chk("t5_resume_addr1", bus.imem_req_addr, 32'h24);
      chk("t5_resume_valid1", bus.imem_req_valid, 1);

      // Reset asserted with three entries buffered.
      lat = 1; dRdy = 1'b0;
      doReset();
      repeat (4) cycle();
      chk("t6_buffered_valid", bus.dec_valid, 1);
      nRst = 1'b0;
      cycle();
      chk("t6_rst_dec_valid", bus.dec_valid, 0);
      chk("t6_rst_req_valid", bus.imem_req_valid, 0);
      cycle();
      nRst = 1'b1; dRdy = 1'b1;
      cycle();
      chk("t6_restart_addr", bus.imem_req_addr, RESET_PC);
      chk("t6_restart_valid", bus.imem_req_valid, 1);
      cycle();
      cycle();
      chk("t6_first_dec_valid", bus.dec_valid, 1);
      chk("t6_first_dec_pc", bus.dec_pc, RESET_PC);

      // Random traffic against the stream reference.
      doReset();
      popCount = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) lat = $urandom_range(1, 3);
         rdy     = ($urandom % 4) != 0;
         dRdy    = ($urandom % 10) < 7;
         redir   = ($urandom % 20) == 0;
         redirPc = $urandom;
         cycle();
      end
      redir = 1'b0;
      chk("rand_progress", popCount > 300, 1);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
